// File: rtl/MD_pkg.sv
// Shared types and sizes for the MD force-evaluation pipeline.
package MD_pkg;

    localparam int unsigned CELL_ID_WIDTH     = 7;
    localparam int unsigned PARTICLE_ID_WIDTH = 8;
    localparam int unsigned NUM_FILTER        = 8;

    typedef logic [31:0] float_data_t;

    typedef struct packed {
        float_data_t x;
        float_data_t y;
        float_data_t z;
    } force_vec_t;

    typedef struct packed {
        force_vec_t                   f;
        logic [CELL_ID_WIDTH-1:0]     cid;
        logic [PARTICLE_ID_WIDTH-1:0] parid;
    } force_packet_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin priority select: first set request at or above
// the pointer, wrapping modulo N.
module rr_priority_select #(
    parameter int unsigned N  = 8,
    parameter int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    // Scan from the pointer upward; the first hit wins.
    always_comb begin
        logic [PW-1:0] w_k;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_k     = '0;
        for (int unsigned off = 0; off < N; off++) begin
            w_k = PW'((32'(i_ptr) + off) % N);
            if (!o_any && i_req[w_k]) begin
                o_any      = 1'b1;
                o_idx      = w_k;
                o_grant[w_k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/force_reg_arbiter.sv
// Drains the per-filter force registers in round-robin order into a single
// valid/ready stream towards the force cache, pulsing a release per grant.
module force_reg_arbiter
    import MD_pkg::*;
#(
    parameter int unsigned NUM_REGS  = NUM_FILTER,
    parameter int unsigned PTR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REGS-1:0]           i_reg_valid,
    input  force_packet_t [NUM_REGS-1:0]  i_regs,
    output logic [NUM_REGS-1:0]           o_release_select,
    output logic                          o_force_valid,
    output force_packet_t                 o_force,
    input  logic                          i_force_ready,
    output logic                          o_idle
);

    arb_state_t           r_state;
    arb_state_t           w_state_next;
    force_packet_t        r_force;
    logic [NUM_REGS-1:0]  r_release;
    logic [PTR_WIDTH-1:0] r_ptr;

    logic [NUM_REGS-1:0]  w_eligible;
    logic [NUM_REGS-1:0]  w_grant_oh;
    logic [PTR_WIDTH-1:0] w_grant_idx;
    logic [PTR_WIDTH-1:0] w_ptr_next;
    logic                 w_any;
    logic                 w_load;
    logic                 w_take;

    // A released slot still shows valid during its pulse cycle; mask it.
    assign w_eligible = i_reg_valid & ~r_release;

    rr_priority_select #(
        .N  (NUM_REGS),
        .PW (PTR_WIDTH)
    ) u_select (
        .i_req   (w_eligible),
        .i_ptr   (r_ptr),
        .o_grant (w_grant_oh),
        .o_idx   (w_grant_idx),
        .o_any   (w_any)
    );

    // Next state, load decision and post-grant pointer.
    always_comb begin
        w_state_next = r_state;
        w_load       = (r_state == ST_EMPTY) || i_force_ready;
        w_take       = w_load && w_any;
        w_ptr_next   = (w_grant_idx == PTR_WIDTH'(NUM_REGS - 1)) ? '0
                                                                 : w_grant_idx + PTR_WIDTH'(1);
        if (w_load) begin
            w_state_next = w_any ? ST_FULL : ST_EMPTY;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output packet, release pulse and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_force   <= '0;
            r_release <= '0;
            r_ptr     <= '0;
        end else begin
            r_release <= w_take ? w_grant_oh : '0;
            if (w_take) begin
                r_force <= i_regs[w_grant_idx];
                r_ptr   <= w_ptr_next;
            end
        end
    end

    assign o_force          = r_force;
    assign o_force_valid    = (r_state == ST_FULL);
    assign o_release_select = r_release;
    assign o_idle           = (r_state == ST_EMPTY) && (i_reg_valid == '0);

endmodule

// File: tb/tb_force_reg_arbiter.sv
// Directed bench for force_reg_arbiter with a slot model and a grant scoreboard.
module tb_force_reg_arbiter;
    import MD_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [7:0]            i_reg_valid;
    force_packet_t [7:0]   i_regs;
    logic [7:0]            o_release_select;
    logic                  o_force_valid;
    force_packet_t         o_force;
    logic                  i_force_ready;
    logic                  o_idle;

    int n_pass  = 0;
    int n_total = 0;

    int            rel_q[$];
    force_packet_t pkt_q[$];
    logic          hold_pending = 1'b0;
    force_packet_t held;

    always #5 clk = ~clk;

    force_reg_arbiter #(.NUM_REGS(8), .PTR_WIDTH(3)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_reg_valid      (i_reg_valid),
        .i_regs           (i_regs),
        .o_release_select (o_release_select),
        .o_force_valid    (o_force_valid),
        .o_force          (o_force),
        .i_force_ready    (i_force_ready),
        .o_idle           (o_idle)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic force_packet_t mk(input int k, input int s);
        force_packet_t p;
        p.f.x   = 32'(k * 1000 + s);
        p.f.y   = ~32'(k);
        p.f.z   = 32'(s * 7 + k);
        p.cid   = 7'(k + s);
        p.parid = 8'(k * 3 + s);
        return p;
    endfunction

    task automatic fill_regs(input int s);
        for (int k = 0; k < 8; k++) i_regs[k] = mk(k, s);
    endtask

    task automatic push(input int k);
        rel_q.push_back(k);
        pkt_q.push_back(i_regs[k]);
    endtask

    // Monitor current cycle, advance one clock, then apply slot clears.
    task automatic cycle();
        logic [7:0] rel;
        logic [7:0] exp_rel;
        rel = o_release_select;
        if (!rst) begin
            if (hold_pending)
                chk("hold_stable", 128'({o_force_valid, o_force}), 128'({1'b1, held}));
            if (rel != 8'h00) begin
                if (rel_q.size() == 0) chk("unexpected_release", 128'(rel), 128'(0));
                else begin
                    exp_rel = 8'h01 << rel_q.pop_front();
                    chk("release", 128'(rel), 128'(exp_rel));
                end
            end
            if (o_force_valid && i_force_ready) begin
                if (pkt_q.size() == 0) chk("unexpected_xfer", 128'(1), 128'(0));
                else chk("xfer_data", 128'(o_force), 128'(pkt_q.pop_front()));
            end
        end
        hold_pending = !rst && o_force_valid && !i_force_ready;
        held = o_force;
        @(posedge clk);
        #1;
        i_reg_valid = i_reg_valid & ~rel;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (o_idle && pkt_q.size() == 0 && rel_q.size() == 0) break;
            cycle();
        end
        chk({tag, "_idle"}, 128'(o_idle), 128'(1));
        chk({tag, "_rel_q"}, 128'(rel_q.size()), 128'(0));
        chk({tag, "_pkt_q"}, 128'(pkt_q.size()), 128'(0));
    endtask

    initial begin
        rst           = 1'b1;
        i_reg_valid   = 8'hFF;
        i_force_ready = 1'b1;
        fill_regs(0);

        // Reset held 3 cycles with every slot valid.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_valid", 128'(o_force_valid), 128'(0));
            chk("rst_release", 128'(o_release_select), 128'(0));
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) push(k);
        cycle();
        chk("first_grant_valid", 128'(o_force_valid), 128'(1));
        chk("first_grant_rel", 128'(o_release_select), 128'(8'h01));

        // Back-to-back drain of all eight slots.
        for (int i = 0; i < 8; i++) begin
            chk("b2b_valid", 128'(o_force_valid), 128'(1));
            cycle();
        end
        chk("b2b_empty", 128'(o_force_valid), 128'(0));
        run_until_idle("b2b", 4);

        // Backpressure: slots 1 and 5, ready low for 4 cycles.
        fill_regs(1);
        i_force_ready = 1'b0;
        i_reg_valid   = 8'h22;
        push(1);
        push(5);
        cycle();
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", 128'(o_force_valid), 128'(1));
            chk("bp_data", 128'(o_force), 128'(mk(1, 1)));
            cycle();
        end
        i_force_ready = 1'b1;
        cycle();
        chk("bp_next_rel", 128'(o_release_select), 128'(8'h20));
        run_until_idle("bp", 6);

        // Wrap-around: pointer at 6, slots 2 and 7.
        fill_regs(2);
        i_reg_valid = 8'h84;
        push(7);
        push(2);
        run_until_idle("wrap", 8);
        // Pointer should now be 3: slots 1 and 3 must grant 3 first.
        fill_regs(3);
        i_reg_valid = 8'h0A;
        push(3);
        push(1);
        run_until_idle("ptr3", 8);

        // Single slot 2.
        fill_regs(4);
        i_reg_valid = 8'h04;
        push(2);
        cycle();
        chk("single_rel", 128'(o_release_select), 128'(8'h04));
        cycle();
        chk("single_rel_gone", 128'(o_release_select), 128'(0));
        cycle();
        chk("single_no_regrant", 128'(o_force_valid), 128'(0));
        run_until_idle("single", 4);

        // New slot appears in the same cycle another slot's release pulses.
        fill_regs(5);
        i_reg_valid = 8'h01;
        push(0);
        cycle();
        i_reg_valid = i_reg_valid | 8'h10;
        push(4);
        cycle();
        chk("simul_valid", 128'(o_force_valid), 128'(1));
        chk("simul_rel", 128'(o_release_select), 128'(8'h10));
        run_until_idle("simul", 6);

        // Mid-operation reset while holding slot 3.
        fill_regs(6);
        i_force_ready = 1'b0;
        i_reg_valid   = 8'h08;
        push(3);
        cycle();
        chk("mid_full", 128'(o_force_valid), 128'(1));
        cycle();
        rst = 1'b1;
        cycle();
        chk("mid_rst_valid", 128'(o_force_valid), 128'(0));
        chk("mid_rst_rel", 128'(o_release_select), 128'(0));
        rel_q.delete();
        pkt_q.delete();
        i_reg_valid   = 8'h00;
        rst           = 1'b0;
        i_force_ready = 1'b1;
        // Pointer back at 0: slots 0 and 6 must grant 0 first.
        fill_regs(7);
        i_reg_valid = 8'h41;
        push(0);
        push(6);
        run_until_idle("mid", 8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
